scan_pattern_ctrl: RTL and testbench
====================================

SCAN_PATTERN_CTRL -- requirements
Module: scan_pattern_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, number of scan flops in the driven chain (legal 1..64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request one load/capture/unload test; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of a running test.
REQ-006 SHALL have port pattern, input, CHAIN_LEN, stimulus vector; bit i lands in chain flop i (flop 0 is nearest scan_in).
REQ-007 SHALL have port expected, input, CHAIN_LEN, expected captured response.
REQ-008 SHALL have port mask, input, CHAIN_LEN, 1 = compare bit, 0 = don't-care.
REQ-009 SHALL have port scan_out, input, 1, serial output of the last chain flop (flop CHAIN_LEN-1).
REQ-010 SHALL have port scan_en, output, 1, chain mode select: 1 = shift, 0 = functional capture.
REQ-011 SHALL have port scan_in, output, 1, serial data into chain flop 0.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of a completed test.
REQ-014 SHALL have port pass, output, 1, result of last completed test; held until next done.
REQ-015 SHALL have port response, output, CHAIN_LEN, unloaded vector of last completed test; held until next done.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, CAPTURE, UNLOAD, DONE; scan_en, scan_in, busy, done registered (no combinational path from inputs).
REQ-017 SHALL, on a rising edge in IDLE with start=1, latch pattern/expected/mask, enter SHIFT, drive scan_en=1 and scan_in=pattern[CHAIN_LEN-1].
REQ-018 SHALL in SHIFT drive pattern bits MSB first, one per cycle, for exactly CHAIN_LEN cycles, so pattern[0] is the last bit presented.
REQ-019 SHALL after the last SHIFT cycle enter CAPTURE for exactly one cycle with scan_en=0, scan_in=0.
REQ-020 SHALL then enter UNLOAD for exactly CHAIN_LEN cycles with scan_en=1, scan_in=0.
REQ-021 SHALL sample scan_out at the rising edge ending UNLOAD cycle k (k=0..CHAIN_LEN-1) into response bit CHAIN_LEN-1-k.
REQ-022 SHALL then enter DONE for one cycle: done=1, scan_en=0, response updated, pass = (((resp ^ expected) & mask) == 0); next state IDLE.
REQ-023 SHALL give latency start-edge to done-high of exactly 2*CHAIN_LEN+2 cycles.
REQ-024 SHALL ignore start while busy; start held high in DONE cycle is not accepted until IDLE (no back-to-back in same cycle).
REQ-025 SHALL on abort=1 in SHIFT/CAPTURE/UNLOAD go to IDLE next edge, scan_en=0, scan_in=0, no done pulse, pass/response unchanged; abort in IDLE/DONE has no effect.
REQ-026 SHALL give abort priority over state progression when both apply on the same edge.
REQ-027 SHALL use a bit counter of width $clog2(CHAIN_LEN+1), reloaded per phase; CHAIN_LEN=1 yields one SHIFT and one UNLOAD cycle.
REQ-028 SHALL treat mask=0 as always-pass.

Reset
REQ-029 SHALL on rst=0 asynchronously force state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, response=0, counter=0, latched vectors=0.
REQ-030 SHALL abandon any running test on reset mid-operation with no done pulse; operation resumes on the first edge after rst rises.

Structure
REQ-031 SHALL take the FSM state enum and the default CHAIN_LEN constant from shared package scan_pkg.
REQ-032 SHALL instantiate one sub-module scan_shift_reg (parallel-load, serial-out left shifter, reused for stimulus and serial-in response).

Verification
REQ-033 Bench SHALL connect the controller to a CHAIN_LEN=4 chain of scan DFFs with functional D tied to 4'b1010.
REQ-034 Load/capture: pattern=4'b0110, expected=4'b1010, mask=4'hF, start pulse -> scan_in sequence 0,1,1,0; scan_en low exactly one cycle; done at cycle 10; pass=1, response=4'b1010.
REQ-035 Mismatch: expected=4'b1011, mask=4'hF -> pass=0; same with mask=4'b1110 -> pass=1.
REQ-036 Abort: assert abort in 2nd UNLOAD cycle -> busy=0 next cycle, no done, prior pass/response kept.
REQ-037 Reset mid-SHIFT: rst=0 in SHIFT cycle 2 -> scan_en=0, busy=0 immediately (asynchronously), then new start completes normally.
REQ-038 Start while busy and CHAIN_LEN=1 build: extra start pulses ignored (one done only); CHAIN_LEN=1 done at cycle 4.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared scan-controller types: FSM state encoding and default chain length.
package scan_pkg;

  localparam int DEF_CHAIN_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load left shifter with serial input at bit 0; exposes its shifted value so the
// owner can read the serial-out bit and the final word without waiting a cycle.
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_CHAIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] shl_dat
);

  logic [WIDTH-1:0] dat;

  assign shl_dat = (dat << 1) | WIDTH'(ser_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat <= '0;
    end else if (load) begin
      dat <= load_dat;
    end else if (shift) begin
      dat <= shl_dat;
    end
  end

endmodule

// File: rtl/scan_pattern_ctrl.sv
// Scan test sequencer: shift pattern in MSB first, one capture cycle, unload and compare.
// Start-to-done is 2*CHAIN_LEN+1 edges; abort returns to IDLE on the next edge.
module scan_pattern_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] exp_q, mask_q, sr_shl;
  logic                 accept, running, last_bit, finish, sr_shift;
  logic                 scan_en_nxt, scan_in_nxt, busy_nxt, done_nxt;

  assign accept   = (state == ST_IDLE) && start;
  assign running  = (state == ST_SHIFT) || (state == ST_CAPTURE) || (state == ST_UNLOAD);
  assign last_bit = (cnt == '0);
  assign finish   = (state == ST_UNLOAD) && last_bit && !abort;
  assign sr_shift = (state == ST_SHIFT) || (state == ST_UNLOAD);

  // One register serves both directions: stimulus drains out of the MSB while shifting,
  // leaving zeros that are then replaced by the unloaded response.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_dat (pattern),
    .shift    (sr_shift),
    .ser_in   ((state == ST_UNLOAD) && scan_out),
    .shl_dat  (sr_shl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      scan_en <= 1'b0;
      scan_in <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      scan_en <= scan_en_nxt;
      scan_in <= scan_in_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_SHIFT;
      ST_SHIFT:   if (last_bit) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_UNLOAD;
      ST_UNLOAD:  if (last_bit) next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (running && abort) next_state = ST_IDLE;
  end

  always_comb begin
    scan_en_nxt = (next_state == ST_SHIFT) || (next_state == ST_UNLOAD);
    busy_nxt    = (next_state != ST_IDLE);
    done_nxt    = (next_state == ST_DONE);
    scan_in_nxt = 1'b0;
    if (next_state == ST_SHIFT) scan_in_nxt = accept ? pattern[CHAIN_LEN-1] : sr_shl[CHAIN_LEN-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
      pass     <= 1'b0;
      response <= '0;
    end else begin
      if (accept || state == ST_CAPTURE) begin
        cnt <= CNT_LAST;
      end else if (next_state == ST_IDLE) begin
        cnt <= '0;
      end else if (sr_shift && !last_bit) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (accept) begin
        exp_q  <= expected;
        mask_q <= mask;
      end
      // The last unload bit is folded in combinationally so DONE already shows the result.
      if (finish) begin
        response <= sr_shl;
        pass     <= (((sr_shl ^ exp_q) & mask_q) == '0);
      end
    end
  end

endmodule

// File: tb/tb_scan_pattern_ctrl.sv
// Directed bench: two controllers (4-flop and 1-flop chains) each driving a modelled scan chain.
// Cycle 1 is the first cycle after the edge that accepts start.
module tb_scan_pattern_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start4, abort4, scan_out4, scan_en4, scan_in4, busy4, done4, pass4;
  logic [3:0] pattern4, expected4, mask4, response4, chain4;
  logic start1, abort1, scan_out1, scan_en1, scan_in1, busy1, done1, pass1;
  logic pattern1, expected1, mask1, response1, chain1;

  int n_cmp = 0;
  int n_err = 0;

  scan_pattern_ctrl #(.CHAIN_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .pattern(pattern4),
    .expected(expected4), .mask(mask4), .scan_out(scan_out4), .scan_en(scan_en4),
    .scan_in(scan_in4), .busy(busy4), .done(done4), .pass(pass4), .response(response4)
  );

  scan_pattern_ctrl #(.CHAIN_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .pattern(pattern1),
    .expected(expected1), .mask(mask1), .scan_out(scan_out1), .scan_en(scan_en1),
    .scan_in(scan_in1), .busy(busy1), .done(done1), .pass(pass1), .response(response1)
  );

  // Scan chains: flop 0 takes scan_in, the last flop drives scan_out; capture loads fixed D.
  always @(posedge clk) begin
    if (scan_en4) chain4 <= {chain4[2:0], scan_in4};
    else          chain4 <= 4'b1010;
    if (scan_en1) chain1 <= scan_in1;
    else          chain1 <= 1'b1;
  end
  assign scan_out4 = chain4[3];
  assign scan_out1 = chain1;

  logic use1;
  logic v_busy, v_done, v_en, v_in;
  assign v_busy = use1 ? busy1    : busy4;
  assign v_done = use1 ? done1    : done4;
  assign v_en   = use1 ? scan_en1 : scan_en4;
  assign v_in   = use1 ? scan_in1 : scan_in4;

  int       r_done_cyc, r_done_cnt, r_en_low;
  logic [3:0] r_sin;
  logic     r_busy_ab, r_en_ab;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ctl(input logic s, input logic a);
    if (use1) begin start1 = s; abort1 = a; end
    else      begin start4 = s; abort4 = a; end
  endtask

  // One test: start pulse, optional abort in cycle abort_cyc, extra start pulses per xstart bit.
  task automatic run(input bit sel, input logic [3:0] p, input logic [3:0] e,
                     input logic [3:0] m, input int abort_cyc, input logic [31:0] xstart);
    int n;
    n = sel ? 1 : 4;
    @(negedge clk);
    use1 = sel;
    if (sel) begin pattern1 = p[0]; expected1 = e[0]; mask1 = m[0]; end
    else     begin pattern4 = p;    expected4 = e;    mask4 = m;    end
    set_ctl(1'b1, 1'b0);
    r_done_cyc = 0; r_done_cnt = 0; r_en_low = 0; r_sin = '0;
    r_busy_ab = 1'bx; r_en_ab = 1'bx;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c <= n) r_sin[n-c] = v_in;
      if (v_busy && !v_done && !v_en) r_en_low++;
      if (v_done) begin
        r_done_cnt++;
        if (r_done_cyc == 0) r_done_cyc = c;
      end
      if (c == abort_cyc + 1) begin r_busy_ab = v_busy; r_en_ab = v_en; end
      set_ctl(xstart[c], c == abort_cyc);
    end
  endtask

  initial begin
    rst = 1'b0; use1 = 1'b0;
    start4 = 0; abort4 = 0; pattern4 = '0; expected4 = '0; mask4 = '0;
    start1 = 0; abort1 = 0; pattern1 = 0;  expected1 = 0;  mask1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy",    32'(busy4),     0);
    check("rst_scan_en", 32'(scan_en4),  0);
    check("rst_scan_in", 32'(scan_in4),  0);
    check("rst_done",    32'(done4),     0);
    check("rst_pass",    32'(pass4),     0);
    check("rst_resp",    32'(response4), 0);
    check("rst_busy1",   32'(busy1),     0);
    rst = 1'b1;

    run(0, 4'b0110, 4'b1010, 4'hF, 0, 32'h0);
    check("t1_scan_in_seq", 32'(r_sin),     32'b0110);
    check("t1_en_low",      32'(r_en_low),  1);
    check("t1_done_cyc",    32'(r_done_cyc), 10);
    check("t1_done_cnt",    32'(r_done_cnt), 1);
    check("t1_pass",        32'(pass4),     1);
    check("t1_resp",        32'(response4), 32'b1010);
    check("t1_idle",        32'(busy4),     0);

    run(0, 4'b0110, 4'b1011, 4'b1110, 0, 32'h0);
    check("masked_pass", 32'(pass4),     1);
    check("masked_resp", 32'(response4), 32'b1010);

    run(0, 4'b1001, 4'b0101, 4'b0000, 0, 32'h0);
    check("mask0_pass",    32'(pass4),  1);
    check("mask0_scan_in", 32'(r_sin),  32'b1001);

    run(0, 4'b0110, 4'b1011, 4'hF, 0, 32'h0);
    check("mismatch_pass", 32'(pass4),     0);
    check("mismatch_resp", 32'(response4), 32'b1010);

    // Abort during the second unload cycle (cycle 7); would have passed if completed.
    run(0, 4'b0110, 4'b1010, 4'hF, 7, 32'h0);
    check("abort_busy_next", 32'(r_busy_ab),  0);
    check("abort_en_next",   32'(r_en_ab),    0);
    check("abort_no_done",   32'(r_done_cnt), 0);
    check("abort_pass_kept", 32'(pass4),      0);
    check("abort_resp_kept", 32'(response4),  32'b1010);

    run(0, 4'b0110, 4'b1010, 4'hF, 0, (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 10));
    check("xstart_done_cnt", 32'(r_done_cnt), 1);
    check("xstart_done_cyc", 32'(r_done_cyc), 10);
    check("xstart_pass",     32'(pass4),      1);

    // Reset in the second SHIFT cycle.
    @(negedge clk);
    use1 = 1'b0; pattern4 = 4'b0110; expected4 = 4'b1010; mask4 = 4'hF; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("mid_busy_before", 32'(busy4), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_scan_en", 32'(scan_en4),  0);
    check("mid_rst_busy",    32'(busy4),     0);
    check("mid_rst_pass",    32'(pass4),     0);
    check("mid_rst_resp",    32'(response4), 0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 4'b0110, 4'b1010, 4'hF, 0, 32'h0);
    check("post_rst_done_cyc", 32'(r_done_cyc), 10);
    check("post_rst_done_cnt", 32'(r_done_cnt), 1);
    check("post_rst_pass",     32'(pass4),      1);
    check("post_rst_resp",     32'(response4),  32'b1010);

    // Single-flop chain with extra start pulses, including one in the DONE cycle.
    run(1, 4'b0001, 4'b0001, 4'b0001, 0, (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 4));
    check("n1_scan_in",  32'(r_sin),      1);
    check("n1_en_low",   32'(r_en_low),   1);
    check("n1_done_cyc", 32'(r_done_cyc), 4);
    check("n1_done_cnt", 32'(r_done_cnt), 1);
    check("n1_pass",     32'(pass1),      1);
    check("n1_resp",     32'(response1),  1);

    run(1, 4'b0000, 4'b0000, 4'b0001, 0, 32'h0);
    check("n1_mismatch_pass", 32'(pass1),     0);
    check("n1_mismatch_resp", 32'(response1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
